gpio_scan_ctrl: RTL and testbench
=================================

# gpio_scan_ctrl

Chip-side scan controller for the GPIO/LA test mode of the OpenRAM test chip. It shifts a 112-bit command word in from `gpio_in` and presents the word's fields to the SRAM macros. On a `global_csb` strobe it performs one SRAM access on the macro selected by the word. It then captures the read data, loads it back into the word, and shifts the word out on `gpio_out`. It sits between the GPIO pad inputs (after mode-select muxing) and the SRAM macro array.

## Interface
- `NUM_SRAMS`, 16: number of macro slots. `sel` values at or above this address no macro.
- `clk` in 1: the gpio clock (`gpio_clk` after mode-select muxing). All logic runs on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `scan_en` in 1: `gpio_scan`.
- `scan_in` in 1: `gpio_in`.
- `sram_load` in 1: `gpio_sram_load`.
- `global_csb` in 1: access strobe, active low.
- `scan_out` out 1: equal to `scan_reg[111]`. Drives `gpio_out`.
- `csb0_o`, `csb1_o` out NUM_SRAMS: per-macro chip selects, active low.
- `web0_o`, `web1_o` out 1: write enables, active low, broadcast to all macros.
- `wmask0_o`, `wmask1_o` out 4: write masks, broadcast.
- `addr0_o`, `addr1_o` out 16: addresses, broadcast.
- `din0_o`, `din1_o` out 32: write data, broadcast.
- `dout0_i`, `dout1_i` in NUM_SRAMS*32: read data, flattened. Macro k occupies bits [32k+31:32k].
- `busy` out 1: high whenever `state` is not IDLE.
- `access_count` out 16: number of accesses performed.

## Operation
- Scan word layout, MSB first: `sel`[111:108], `addr0`[107:92], `din0`[91:60], `csb0`[59], `web0`[58], `wmask0`[57:54], `addr1`[53:38], `din1`[37:6], `csb1`[5], `web1`[4], `wmask1`[3:0].
- Field values drive `addr*_o`, `din*_o`, `web*_o` and `wmask*_o` directly.
- State machine states:
  - IDLE: shift, load and accept strobes.
  - ACCESS: capture cycle.
  - WAIT: wait for the strobe to be released.
- Transitions:
  - IDLE to ACCESS when the edge samples `global_csb`=0 and `scan_en`=0. This edge also latches `sel_q` = `sel`, `rd0_q` = `!csb0 & web0` and `rd1_q` = `!csb1 & web1`.
  - ACCESS always leaves after one cycle: to WAIT if `global_csb`=0, else to IDLE.
  - WAIT goes to IDLE on `global_csb`=1.
- Chip select, combinational: `csb0_o[k]` is low only when all of the following hold. Same rule for port 1.
  - `state`=IDLE
  - `global_csb`=0
  - `scan_en`=0
  - `csb0` field =0
  - `sel`=k
- Consequence: the macro samples its command on the same edge that moves the FSM from IDLE to ACCESS.
- Capture, on the ACCESS edge:
  - `dout0_q` <= `dout0_i` slice `sel_q` if `rd0_q`; port 1 likewise.
  - If `sel_q` >= NUM_SRAMS, the captured value is 0.
  - Ports that were not reads hold their previous value.
  - `access_count` increments; it wraps from 0xFFFF to 0.
- In IDLE, priority is `sram_load` > `scan_en`:
  - `sram_load`=1: `din0` field <= `dout0_q` and `din1` field <= `dout1_q`. All other bits are unchanged.
  - Else `scan_en`=1: `scan_reg` <= {`scan_reg`[110:0], `scan_in`}.
- In ACCESS and WAIT, `scan_en` and `sram_load` are ignored and `scan_reg` holds.

## Timing
- Reset values:
  - `scan_reg` = all ones, so both csb fields are high and idle.
  - `csb*_o` all ones.
  - `dout*_q` = 0, `sel_q` = 0, `rd*_q` = 0.
  - `access_count` = 0, `state` = IDLE, `busy` = 0.
  - `scan_out` = 1.
- Reset asserted mid-access: all chip selects deassert immediately, with no capture and no count.
- Latency, with the strobe low for exactly one cycle:
  - Edge E0: macro access.
  - Edge E1: capture.
  - Edge E2: `sram_load` accepted.
  - Edge E3 onward: first shift. `scan_out` shows `sel`[3] immediately after the load, so 112 shift edges return the whole word.
- A strobe held low for N cycles gives exactly one access; a new access needs a release of at least one cycle.
- `global_csb`=0 while `scan_en`=1: no access, and the shift continues.
- Capture timing assumes macro `dout` is valid one cycle after the access edge.

## Test plan
- Reset, then check outputs: `csb0_o` = `csb1_o` = 0xFFFF, `scan_out`=1, `access_count`=0.
- Shift in a write of `din0`=0x00000005 to `addr0`=1 with `sel`=5 (port 1 `csb`=1), then strobe for one cycle:
  - only `csb0_o[5]` goes low, for one cycle;
  - `web0_o`=0, `addr0_o`=1, `din0_o`=5;
  - `access_count`=1.
- Dual-port read, with model macro 3 returning `addr0` and `addr1` data 3 and 0x18: strobe, then load, then 112 shifts. `scan_out` reproduces the word with `din0`=3 and `din1`=0x18.
- Hold the strobe low for 5 cycles: one chip-select pulse; `busy` is high for 5 cycles; `access_count` +1.
- Strobe with `sel`=12 and `NUM_SRAMS`=11: no chip select falls; the load returns `din0`=`din1`=0.
- Assert `sram_load` and `scan_en` together: the load wins. Assert reset during ACCESS: `csb*_o` are all high within the same cycle and `access_count` is unchanged.

Source files
------------

// File: rtl/gpio_scan_ctrl_if.sv
// SRAM-side bus of the GPIO scan controller: per-macro chip selects,
// broadcast command fields and flattened per-macro read data.
interface gpio_scan_ctrl_if #(
  parameter int NUM_SRAMS = 16
);
  logic [NUM_SRAMS-1:0]    csb0_o;
  logic [NUM_SRAMS-1:0]    csb1_o;
  logic                    web0_o;
  logic                    web1_o;
  logic [3:0]              wmask0_o;
  logic [3:0]              wmask1_o;
  logic [15:0]             addr0_o;
  logic [15:0]             addr1_o;
  logic [31:0]             din0_o;
  logic [31:0]             din1_o;
  logic [NUM_SRAMS*32-1:0] dout0_i;
  logic [NUM_SRAMS*32-1:0] dout1_i;

  modport master (
    output csb0_o,
    output csb1_o,
    output web0_o,
    output web1_o,
    output wmask0_o,
    output wmask1_o,
    output addr0_o,
    output addr1_o,
    output din0_o,
    output din1_o,
    input  dout0_i,
    input  dout1_i
  );

  modport slave (
    input  csb0_o,
    input  csb1_o,
    input  web0_o,
    input  web1_o,
    input  wmask0_o,
    input  wmask1_o,
    input  addr0_o,
    input  addr1_o,
    input  din0_o,
    input  din1_o,
    output dout0_i,
    output dout1_i
  );
endinterface

// File: rtl/gpio_scan_ctrl.sv
// GPIO/LA scan controller: shifts a 112-bit command word, runs one
// SRAM access per strobe, captures read data and shifts it back out.
module gpio_scan_ctrl #(
  parameter int NUM_SRAMS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_en,
  input  logic              scan_in,
  input  logic              sram_load,
  input  logic              global_csb,
  output logic              scan_out,
  gpio_scan_ctrl_if.master  sram,
  output logic              busy,
  output logic [15:0]       access_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  logic [1:0]   state;
  logic [111:0] scan_reg;
  logic [3:0]   sel_q;
  logic         rd0_q;
  logic         rd1_q;
  logic [31:0]  dout0_q;
  logic [31:0]  dout1_q;
  logic [31:0]  rdata0;
  logic [31:0]  rdata1;

  logic [3:0]   sel;
  logic         f_csb0;
  logic         f_web0;
  logic         f_csb1;
  logic         f_web1;
  logic         idle;
  logic         acc_req;
  logic         do_load;
  logic         do_shift;

  assign sel    = scan_reg[111:108];
  assign f_csb0 = scan_reg[59];
  assign f_web0 = scan_reg[58];
  assign f_csb1 = scan_reg[5];
  assign f_web1 = scan_reg[4];

  assign sram.addr0_o  = scan_reg[107:92];
  assign sram.din0_o   = scan_reg[91:60];
  assign sram.web0_o   = f_web0;
  assign sram.wmask0_o = scan_reg[57:54];
  assign sram.addr1_o  = scan_reg[53:38];
  assign sram.din1_o   = scan_reg[37:6];
  assign sram.web1_o   = f_web1;
  assign sram.wmask1_o = scan_reg[3:0];

  assign scan_out = scan_reg[111];
  assign idle     = (state == ST_IDLE);
  assign busy     = !idle;
  assign acc_req  = idle && !global_csb && !scan_en;
  assign do_load  = idle && sram_load;
  assign do_shift = idle && !sram_load && scan_en;

  // Selects are combinational so the macro samples on the IDLE->ACCESS edge
  always_comb begin
    sram.csb0_o = '1;
    sram.csb1_o = '1;
    for (int k = 0; k < NUM_SRAMS; k++) begin
      if (acc_req && !f_csb0 && int'(sel) == k)
        sram.csb0_o[k] = 1'b0;
      if (acc_req && !f_csb1 && int'(sel) == k)
        sram.csb1_o[k] = 1'b0;
    end
  end

  // Out-of-range selects fall through to zero
  always_comb begin
    rdata0 = '0;
    rdata1 = '0;
    for (int k = 0; k < NUM_SRAMS; k++) begin
      if (int'(sel_q) == k) begin
        rdata0 = sram.dout0_i[32*k +: 32];
        rdata1 = sram.dout1_i[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (acc_req)
            state <= ST_ACCESS;
        end
        ST_ACCESS: begin
          state <= global_csb ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (global_csb)
            state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= '0;
      rd0_q <= 1'b0;
      rd1_q <= 1'b0;
    end else if (acc_req) begin
      sel_q <= sel;
      rd0_q <= !f_csb0 && f_web0;
      rd1_q <= !f_csb1 && f_web1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout0_q      <= '0;
      dout1_q      <= '0;
      access_count <= '0;
    end else if (state == ST_ACCESS) begin
      if (rd0_q)
        dout0_q <= rdata0;
      if (rd1_q)
        dout1_q <= rdata1;
      access_count <= access_count + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_reg <= '1;
    end else begin
      unique case (1'b1)
        do_load: begin
          scan_reg[91:60] <= dout0_q;
          scan_reg[37:6]  <= dout1_q;
        end
        do_shift: begin
          scan_reg <= {scan_reg[110:0], scan_in};
        end
        default: begin
          scan_reg <= scan_reg;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_scan_ctrl.sv
// Bench for gpio_scan_ctrl: 16-slot and 11-slot instances in lockstep,
// macro models on the bus, transaction-level golden memory model.
module tb_gpio_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, scan_en, scan_in, sram_load, global_csb;
  logic so16, so11, busy16, busy11;
  logic [15:0] cnt16, cnt11;

  gpio_scan_ctrl_if #(.NUM_SRAMS(16)) b16();
  gpio_scan_ctrl_if #(.NUM_SRAMS(11)) b11();

  gpio_scan_ctrl #(.NUM_SRAMS(16)) u_dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .scan_in(scan_in),
    .sram_load(sram_load), .global_csb(global_csb), .scan_out(so16),
    .sram(b16.master), .busy(busy16), .access_count(cnt16)
  );

  gpio_scan_ctrl #(.NUM_SRAMS(11)) u_dut11 (
    .clk(clk), .reset(reset), .scan_en(scan_en), .scan_in(scan_in),
    .sram_load(sram_load), .global_csb(global_csb), .scan_out(so11),
    .sram(b11.master), .busy(busy11), .access_count(cnt11)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [111:0] mk(
    input logic [3:0] s, input logic [15:0] a0, input logic [31:0] d0,
    input logic c0, input logic w0, input logic [3:0] m0,
    input logic [15:0] a1, input logic [31:0] d1,
    input logic c1, input logic w1, input logic [3:0] m1);
    return {s, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
  endfunction

  function automatic int key(input int inst, input int k, input logic [15:0] a);
    return inst * (1 << 20) + k * 65536 + int'(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] m);
    logic [31:0] v;
    v = old;
    for (int b = 0; b < 4; b++)
      if (m[b]) v[8*b +: 8] = d[8*b +: 8];
    return v;
  endfunction

  // ---------------- macro models driving dout ----------------
  logic [31:0] mem [int];
  logic [31:0] md0 [2][16];
  logic [31:0] md1 [2][16];
  logic [31:0] nd0 [2][16];
  logic [31:0] nd1 [2][16];

  task automatic mread(input int inst, input int k, input logic csb,
                       input logic web, input logic [15:0] a, input int p);
    int kk;
    logic [31:0] v;
    if (!csb && web) begin
      kk = key(inst, k, a);
      v = mem.exists(kk) ? mem[kk] : 32'd0;
      if (p == 0) nd0[inst][k] = v;
      else nd1[inst][k] = v;
    end
  endtask

  task automatic mwrite(input int inst, input int k, input logic csb,
                        input logic web, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] m);
    int kk;
    if (!csb && !web) begin
      kk = key(inst, k, a);
      mem[kk] = merge(mem.exists(kk) ? mem[kk] : 32'd0, d, m);
    end
  endtask

  always @(posedge clk) begin
    nd0 = md0;
    nd1 = md1;
    for (int k = 0; k < 16; k++) begin
      mread(0, k, b16.csb0_o[k], b16.web0_o, b16.addr0_o, 0);
      mread(0, k, b16.csb1_o[k], b16.web1_o, b16.addr1_o, 1);
    end
    for (int k = 0; k < 11; k++) begin
      mread(1, k, b11.csb0_o[k], b11.web0_o, b11.addr0_o, 0);
      mread(1, k, b11.csb1_o[k], b11.web1_o, b11.addr1_o, 1);
    end
    for (int k = 0; k < 16; k++) begin
      mwrite(0, k, b16.csb0_o[k], b16.web0_o, b16.addr0_o, b16.din0_o, b16.wmask0_o);
      mwrite(0, k, b16.csb1_o[k], b16.web1_o, b16.addr1_o, b16.din1_o, b16.wmask1_o);
    end
    for (int k = 0; k < 11; k++) begin
      mwrite(1, k, b11.csb0_o[k], b11.web0_o, b11.addr0_o, b11.din0_o, b11.wmask0_o);
      mwrite(1, k, b11.csb1_o[k], b11.web1_o, b11.addr1_o, b11.din1_o, b11.wmask1_o);
    end
    md0 <= nd0;
    md1 <= nd1;
  end

  always_comb begin
    b16.dout0_i = '0;
    b16.dout1_i = '0;
    b11.dout0_i = '0;
    b11.dout1_i = '0;
    for (int k = 0; k < 16; k++) begin
      b16.dout0_i[32*k +: 32] = md0[0][k];
      b16.dout1_i[32*k +: 32] = md1[0][k];
    end
    for (int k = 0; k < 11; k++) begin
      b11.dout0_i[32*k +: 32] = md0[1][k];
      b11.dout1_i[32*k +: 32] = md1[1][k];
    end
  end

  // ---------------- golden transaction model ----------------
  logic [31:0]  gmem [int];
  logic [111:0] exp_word [2];
  logic [31:0]  edq0 [2];
  logic [31:0]  edq1 [2];
  logic [15:0]  ef0 [2];
  logic [15:0]  ef1 [2];
  int           ep0 [2];
  int           ep1 [2];
  logic [15:0]  exp_cnt;

  function automatic logic [31:0] gread(input int kk);
    return gmem.exists(kk) ? gmem[kk] : 32'd0;
  endfunction

  task automatic model_access(input int inst, input logic [111:0] w);
    int s, nslots;
    logic inr;
    logic [31:0] r0, r1;
    s = int'(w[111:108]);
    nslots = (inst == 0) ? 16 : 11;
    inr = (s < nslots);
    r0 = inr ? gread(key(inst, s, w[107:92])) : 32'd0;
    r1 = inr ? gread(key(inst, s, w[53:38])) : 32'd0;
    if (!w[59] && w[58]) edq0[inst] = r0;
    if (!w[5] && w[4]) edq1[inst] = r1;
    if (inr && !w[59] && !w[58])
      gmem[key(inst, s, w[107:92])] = merge(gread(key(inst, s, w[107:92])), w[91:60], w[57:54]);
    if (inr && !w[5] && !w[4])
      gmem[key(inst, s, w[53:38])] = merge(gread(key(inst, s, w[53:38])), w[37:6], w[3:0]);
    ep0[inst] = (inr && !w[59]) ? 1 : 0;
    ep1[inst] = (inr && !w[5]) ? 1 : 0;
    ef0[inst] = ep0[inst] != 0 ? ~(16'd1 << s) : 16'hFFFF;
    ef1[inst] = ep1[inst] != 0 ? ~(16'd1 << s) : 16'hFFFF;
  endtask

  // ---------------- stimulus helpers ----------------
  logic [111:0] last_out [2];
  int           pulses0 [2];
  int           pulses1 [2];
  int           busyc [2];
  logic [15:0]  first0 [2];
  logic [15:0]  first1 [2];

  task automatic shift_word(input logic [111:0] w);
    for (int i = 111; i >= 0; i--) begin
      @(negedge clk);
      scan_en = 1'b1;
      scan_in = w[i];
      last_out[0][i] = so16;
      last_out[1][i] = so11;
    end
    @(negedge clk);
    scan_en = 1'b0;
    chk("shift_out16", 128'(last_out[0]), 128'(exp_word[0]));
    chk("shift_out11", 128'(last_out[1]), 128'(exp_word[1]));
    exp_word[0] = w;
    exp_word[1] = w;
  endtask

  task automatic samp();
    logic [15:0] c0 [2];
    logic [15:0] c1 [2];
    c0[0] = b16.csb0_o;
    c1[0] = b16.csb1_o;
    c0[1] = {5'h1f, b11.csb0_o};
    c1[1] = {5'h1f, b11.csb1_o};
    if (busy16) busyc[0]++;
    if (busy11) busyc[1]++;
    for (int i = 0; i < 2; i++) begin
      if (c0[i] != 16'hFFFF) begin pulses0[i]++; first0[i] = c0[i]; end
      if (c1[i] != 16'hFFFF) begin pulses1[i]++; first1[i] = c1[i]; end
    end
  endtask

  task automatic do_access(input int n);
    int guard;
    for (int i = 0; i < 2; i++) begin
      pulses0[i] = 0; pulses1[i] = 0; busyc[i] = 0;
      first0[i] = 16'hFFFF; first1[i] = 16'hFFFF;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      global_csb = 1'b0;
      scan_en = 1'b0;
      sram_load = 1'b0;
      #1 samp();
    end
    @(negedge clk);
    global_csb = 1'b1;
    #1 samp();
    guard = 0;
    while ((busy16 || busy11) && guard < 8) begin
      @(negedge clk);
      #1 samp();
      guard++;
    end
    chk("busy_release", 128'(guard < 8), 128'(1));
    for (int i = 0; i < 2; i++) begin
      model_access(i, exp_word[i]);
      chk("csb0_pulses", 128'(pulses0[i]), 128'(ep0[i]));
      chk("csb1_pulses", 128'(pulses1[i]), 128'(ep1[i]));
      chk("csb0_value", 128'(first0[i]), 128'(ef0[i]));
      chk("csb1_value", 128'(first1[i]), 128'(ef1[i]));
      chk("busy_cycles", 128'(busyc[i]), 128'(n));
    end
    exp_cnt = exp_cnt + 16'd1;
    chk("count16", 128'(cnt16), 128'(exp_cnt));
    chk("count11", 128'(cnt11), 128'(exp_cnt));
  endtask

  task automatic do_load();
    @(negedge clk);
    sram_load = 1'b1;
    @(negedge clk);
    sram_load = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_word[i][91:60] = edq0[i];
      exp_word[i][37:6]  = edq1[i];
    end
  endtask

  typedef struct {
    logic [3:0]  sel;
    logic        c0;
    logic        c1;
    logic        se;
    logic        g;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [10:0] e11;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [111:0] w;
    tbl[0] = '{4'd5,  1'b0, 1'b1, 1'b0, 1'b0, 16'hFFDF, 16'hFFFF, 11'h7DF};
    tbl[1] = '{4'd5,  1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 11'h7FF};
    tbl[2] = '{4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 11'h7FF};
    tbl[3] = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFE, 16'hFFFE, 11'h7FE};
    tbl[4] = '{4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h7FFF, 11'h7FF};
    tbl[5] = '{4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 16'hEFFF, 16'hEFFF, 11'h7FF};
    tbl[6] = '{4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFBFF, 16'hFFFF, 11'h3FF};

    reset = 1'b1; scan_en = 1'b0; scan_in = 1'b0;
    sram_load = 1'b0; global_csb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_word[i] = '1; edq0[i] = '0; edq1[i] = '0;
    end
    exp_cnt = '0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_csb0", 128'(b16.csb0_o), 128'(16'hFFFF));
    chk("rst_csb1", 128'(b16.csb1_o), 128'(16'hFFFF));
    chk("rst_csb0_11", 128'(b11.csb0_o), 128'(11'h7FF));
    chk("rst_scan_out", 128'(so16), 128'(1));
    chk("rst_count", 128'(cnt16), 128'(0));
    chk("rst_busy", 128'(busy16), 128'(0));

    // combinational chip-select decode, probed between edges
    for (int i = 0; i < 7; i++) begin
      w = mk(tbl[i].sel, 16'h0123, 32'hA5A50000 + i, tbl[i].c0, 1'b1, 4'hF,
             16'h0456, 32'h5A5A0000, tbl[i].c1, 1'b1, 4'hF);
      shift_word(w);
      global_csb = tbl[i].g;
      scan_en = tbl[i].se;
      #1;
      chk("tbl_csb0", 128'(b16.csb0_o), 128'(tbl[i].e0));
      chk("tbl_csb1", 128'(b16.csb1_o), 128'(tbl[i].e1));
      chk("tbl_csb0_11", 128'(b11.csb0_o), 128'(tbl[i].e11));
      global_csb = 1'b1;
      scan_en = 1'b0;
    end

    // single-port write to macro 5
    shift_word(mk(4'd5, 16'd1, 32'd5, 1'b0, 1'b0, 4'hF,
                  16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    chk("wr_web0", 128'(b16.web0_o), 128'(0));
    chk("wr_addr0", 128'(b16.addr0_o), 128'(1));
    chk("wr_din0", 128'(b16.din0_o), 128'(5));
    do_access(1);
    chk("wr_csb0_5", 128'(first0[0]), 128'(16'hFFDF));
    chk("wr_count", 128'(cnt16), 128'(1));
    do_load();

    // dual-port read of macro 3 after seeding it
    shift_word(mk(4'd3, 16'h10, 32'd3, 1'b0, 1'b0, 4'hF,
                  16'h20, 32'h18, 1'b0, 1'b0, 4'hF));
    do_access(1);
    do_load();
    shift_word(mk(4'd3, 16'h10, 32'hDEAD, 1'b0, 1'b1, 4'hF,
                  16'h20, 32'hBEEF, 1'b0, 1'b1, 4'hF));
    do_access(1);
    do_load();
    shift_word(mk(4'd15, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0,
                  16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    chk("dual_read_word", 128'(last_out[0]),
        128'(mk(4'd3, 16'h10, 32'd3, 1'b0, 1'b1, 4'hF,
                16'h20, 32'h18, 1'b0, 1'b1, 4'hF)));

    // strobe held low for five cycles
    do_access(5);
    chk("hold5_busy", 128'(busyc[0]), 128'(5));
    do_load();

    // select beyond the 11-slot array
    shift_word(mk(4'd12, 16'd1, 32'hFF, 1'b0, 1'b1, 4'hF,
                  16'd2, 32'hEE, 1'b0, 1'b1, 4'hF));
    do_access(1);
    chk("sel12_no_csb", 128'(pulses0[1] + pulses1[1]), 128'(0));
    do_load();
    shift_word(mk(4'd0, 16'd0, 32'd0, 1'b1, 1'b1, 4'h0,
                  16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    chk("sel12_din0", 128'(last_out[1][91:60]), 128'(0));
    chk("sel12_din1", 128'(last_out[1][37:6]), 128'(0));

    // load and shift together: load wins
    shift_word(mk(4'd9, 16'h3, 32'h11111111, 1'b1, 1'b1, 4'h0,
                  16'h4, 32'h22222222, 1'b1, 1'b1, 4'h0));
    @(negedge clk);
    sram_load = 1'b1;
    scan_en = 1'b1;
    scan_in = 1'b0;
    @(negedge clk);
    sram_load = 1'b0;
    scan_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_word[i][91:60] = edq0[i];
      exp_word[i][37:6]  = edq1[i];
    end
    chk("load_wins_sel", 128'(b16.addr0_o), 128'(16'h3));

    // randomized transactions against the golden model
    for (int t = 0; t < 30; t++) begin
      w = mk(4'($urandom_range(0, 15)), 16'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom),
             16'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 3) == 0), 1'($urandom), 4'($urandom));
      shift_word(w);
      do_access($urandom_range(1, 4));
      do_load();
    end
    shift_word('1);

    // reset while in ACCESS
    shift_word(mk(4'd2, 16'd7, 32'hCAFE0001, 1'b0, 1'b0, 4'hF,
                  16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    @(negedge clk);
    global_csb = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 128'(busy16), 128'(1));
    reset = 1'b1;
    #1;
    chk("mid_rst_csb0", 128'(b16.csb0_o), 128'(16'hFFFF));
    chk("mid_rst_csb1", 128'(b16.csb1_o), 128'(16'hFFFF));
    chk("mid_rst_csb0_11", 128'(b11.csb0_o), 128'(11'h7FF));
    chk("mid_rst_count", 128'(cnt16), 128'(0));
    chk("mid_rst_busy", 128'(busy16), 128'(0));
    for (int i = 0; i < 2; i++) begin
      model_access(i, exp_word[i]);
      exp_word[i] = '1; edq0[i] = '0; edq1[i] = '0;
    end
    exp_cnt = '0;
    @(negedge clk);
    global_csb = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    shift_word(mk(4'd2, 16'd7, 32'd0, 1'b0, 1'b1, 4'hF,
                  16'd0, 32'd0, 1'b1, 1'b1, 4'h0));
    do_access(1);
    do_load();
    shift_word('1);
    chk("post_rst_rd", 128'(last_out[0][91:60]), 128'(32'hCAFE0001));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
